// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the async FIFO.
// It brings the Gray write pointer into rclk through two flops and owns the read pointer.
// It produces the empty, almost-empty and fill-level flags.
// Words read from fifo_mem are prefetched into a 2-entry output buffer.
// The buffer drives a valid/ready stream at up to one word per cycle.
module fifo_rd_ctrl #(
  parameter int DEPTH     = 256,
  parameter int DATA_SIZE = 8,
  parameter int PTR_SIZE  = 8,
  parameter int AE_THRESH = 4
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic [PTR_SIZE:0]    g_wptr_async,
  input  logic [DATA_SIZE-1:0] mem_data,
  output logic                 r_en,
  output logic [PTR_SIZE:0]    b_rptr,
  output logic [PTR_SIZE:0]    g_rptr,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [PTR_SIZE:0]    fill_level,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int PW = PTR_SIZE + 1;

  // Pointer MSB is the wrap bit, so the memory must be exactly 2**PTR_SIZE deep.
  if (DEPTH != (1 << PTR_SIZE)) begin : g_bad_depth
    $error("fifo_rd_ctrl: DEPTH must equal 2**PTR_SIZE");
  end

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0]        wq1_q, wq2_q;
  logic [PW-1:0]        b_rptr_q, g_rptr_q;
  logic                 pend_q;
  logic [1:0]           occ_q, occ_d;
  logic [DATA_SIZE-1:0] head_q, head_d, tail_q, tail_d;
  logic                 empty_q, ae_q;
  logic [PW-1:0]        fill_q;

  logic                 pop;
  logic [2:0]           slots;
  logic [PW-1:0]        rn, fill_d;

  // Issue a read only when memory holds data and the word will have a free buffer slot on arrival.
  always_comb begin
    pop    = (occ_q != 2'd0) && out_ready;
    slots  = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    r_en   = rrst_n && !empty_q && (slots < 3'd2);
    rn     = b_rptr_q + {{(PW-1){1'b0}}, r_en};
    fill_d = gray2bin(wq2_q) - rn;
  end

  // Output buffer next state: pop from the head and push in-flight memory data at the tail, keeping order.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({pend_q, pop})
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) head_d = mem_data;
        else               tail_d = mem_data;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) head_d = mem_data;
        else begin
          head_d = tail_q;
          tail_d = mem_data;
        end
      end
      default: ;
    endcase
  end

  // Synchroniser, read pointer, flags and buffer state.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      wq1_q    <= '0;
      wq2_q    <= '0;
      b_rptr_q <= '0;
      g_rptr_q <= '0;
      pend_q   <= 1'b0;
      occ_q    <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
      fill_q   <= '0;
    end else begin
      wq1_q    <= g_wptr_async;
      wq2_q    <= wq1_q;
      b_rptr_q <= rn;
      g_rptr_q <= bin2gray(rn);
      pend_q   <= r_en;
      occ_q    <= occ_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      empty_q  <= (bin2gray(rn) == wq2_q);
      fill_q   <= fill_d;
      ae_q     <= (fill_d <= PW'(AE_THRESH));
    end
  end

  assign b_rptr       = b_rptr_q;
  assign g_rptr       = g_rptr_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign fill_level   = fill_q;
  assign out_data     = head_q;
  assign out_valid    = (occ_q != 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a 1-cycle-latency memory model.
module tb_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic [8:0] g_wptr_async = '0;
  logic [7:0] mem_data = '0;
  logic       r_en;
  logic [8:0] b_rptr, g_rptr, fill_level;
  logic       empty, almost_empty, out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;

  logic [7:0] mem [256];
  logic [7:0] got [$];
  int         checks = 0;
  int         failures = 0;
  int         rd_viol = 0;

  fifo_rd_ctrl #(.DEPTH(256), .DATA_SIZE(8), .PTR_SIZE(8), .AE_THRESH(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .g_wptr_async(g_wptr_async), .mem_data(mem_data),
    .r_en(r_en), .b_rptr(b_rptr), .g_rptr(g_rptr), .empty(empty),
    .almost_empty(almost_empty), .fill_level(fill_level), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 rclk = ~rclk;

  // fifo_mem: synchronous read, one cycle latency
  always @(posedge rclk) if (r_en) mem_data <= mem[b_rptr[7:0]];

  // stream monitor: record accepted words, flag reads issued while empty
  always @(posedge rclk) begin
    if (rrst_n && out_valid && out_ready) got.push_back(out_data);
    if (rrst_n && r_en && empty) rd_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic rst_dut();
    @(posedge rclk); #1;
    rrst_n = 1'b0;
    g_wptr_async = '0;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("rst_b_rptr", 32'(b_rptr), 0);
    chk("rst_g_rptr", 32'(g_rptr), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_r_en", 32'(r_en), 0);
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_data", 32'(out_data), 0);
    rrst_n = 1'b1;
    got.delete();
  endtask

  initial begin
    int n;
    bit done;
    logic [7:0] exp6 [256];

    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_dut();

    // T2: single word, latency
    mem[0] = 8'hA5;
    out_ready = 1'b1;
    @(posedge rclk); #1 g_wptr_async = 9'd1;
    repeat (3) @(posedge rclk);
    @(negedge rclk) chk("t2_empty_e3", 32'(empty), 0);
    @(posedge rclk); @(negedge rclk) chk("t2_valid_e4", 32'(out_valid), 0);
    @(posedge rclk); @(negedge rclk);
    chk("t2_valid_e5", 32'(out_valid), 1);
    chk("t2_data_e5", 32'(out_data), 32'hA5);
    @(posedge rclk); @(negedge rclk);
    chk("t2_valid_e6", 32'(out_valid), 0);
    chk("t2_b_rptr", 32'(b_rptr), 1);
    chk("t2_g_rptr", 32'(g_rptr), 1);
    chk("t2_empty", 32'(empty), 1);

    // T3: backpressure then 8-word burst
    rst_dut();
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
    out_ready = 1'b0;
    @(posedge rclk); #1 g_wptr_async = 9'h00C;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk);
      if (r_en) n++;
    end
    chk("t3_r_en_pulses", 32'(n), 2);
    chk("t3_b_rptr", 32'(b_rptr), 2);
    chk("t3_valid_held", 32'(out_valid), 1);
    chk("t3_data_held", 32'(out_data), 32'h10);
    chk("t3_fill_stall", 32'(fill_level), 6);
    @(posedge rclk); #1 out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk);
      chk($sformatf("t3_burst%0d", i), {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'(8'h10 + i)});
    end
    @(negedge rclk);
    chk("t3_valid_end", 32'(out_valid), 0);
    chk("t3_fill_end", 32'(fill_level), 0);
    chk("t3_empty_end", 32'(empty), 1);

    // T4: pointer wrap
    rst_dut();
    for (int i = 0; i < 255; i++) mem[i] = 8'(i);
    out_ready = 1'b1;
    @(posedge rclk); #1 g_wptr_async = 9'h080;
    done = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge rclk);
      if (b_rptr == 9'd255 && empty && !out_valid) done = 1;
    end
    chk("t4_drain_done", 32'(done), 1);
    repeat (3) @(negedge rclk);
    chk("t4_drain_cnt", 32'(got.size()), 255);
    n = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] != 8'(i)) n++;
    chk("t4_drain_order", 32'(n), 0);
    got.delete();
    mem[255] = 8'hAB;
    mem[0]   = 8'hCD;
    @(posedge rclk); #1 g_wptr_async = 9'h181;
    repeat (12) @(negedge rclk);
    chk("t4_wrap_cnt", 32'(got.size()), 2);
    if (got.size() == 2) begin
      chk("t4_word255", 32'(got[0]), 32'hAB);
      chk("t4_word0", 32'(got[1]), 32'hCD);
    end
    chk("t4_b_rptr", 32'(b_rptr), 32'h101);
    chk("t4_g_rptr", 32'(g_rptr), 32'h181);
    chk("t4_empty", 32'(empty), 1);

    // T5: almost_empty threshold
    rst_dut();
    out_ready = 1'b0;
    @(posedge rclk); #1 g_wptr_async = 9'h007;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge rclk);
      if (!empty) done = 1;
    end
    chk("t5_nonempty", 32'(done), 1);
    chk("t5_fill5", 32'(fill_level), 5);
    chk("t5_ae_at5", 32'(almost_empty), 0);
    @(negedge rclk);
    chk("t5_fill4", 32'(fill_level), 4);
    chk("t5_ae_at4", 32'(almost_empty), 1);

    // T6: 256 random words, random backpressure
    rst_dut();
    for (int i = 0; i < 256; i++) begin
      exp6[i] = 8'($urandom);
      mem[i]  = exp6[i];
    end
    rd_viol = 0;
    @(posedge rclk); #1 g_wptr_async = 9'h180;
    for (int c = 0; c < 3000 && got.size() < 256; c++) begin
      @(posedge rclk); #1 out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    repeat (4) @(negedge rclk);
    chk("t6_count", 32'(got.size()), 256);
    n = 0;
    for (int i = 0; i < got.size() && i < 256; i++) if (got[i] != exp6[i]) n++;
    chk("t6_order", 32'(n), 0);
    chk("t6_rd_while_empty", 32'(rd_viol), 0);
    chk("t6_b_rptr", 32'(b_rptr), 32'h100);
    chk("t6_empty", 32'(empty), 1);

    // T1: reset in the middle of traffic
    got.delete();
    @(posedge rclk); #1 g_wptr_async = 9'h140;
    repeat (10) @(negedge rclk);
    chk("t1_traffic", 32'(got.size() > 0), 1);
    rst_dut();
    repeat (6) @(negedge rclk);
    chk("t1_post_empty", 32'(empty), 1);
    chk("t1_post_valid", 32'(out_valid), 0);
    chk("t1_post_b_rptr", 32'(b_rptr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
